// File: rtl/irq_ack_sequencer.sv
// Edge-captured 3-bus interrupt arbiter: request edge -> vector valid in 3 edges, back-to-back 3 cycles apart; vector held until vec_ready or timeout.
// Optional per-channel masking with IRQ_MASK_EN (masked bits still latch pending but cannot win).
module irq_ack_sequencer #(
    parameter int NCH         = 9,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [NCH-1:0] i_req_a,
    input  logic [NCH-1:0] i_req_b,
    input  logic [NCH-1:0] i_req_c,
`ifdef IRQ_MASK_EN
    input  logic [NCH-1:0] i_mask_a,
    input  logic [NCH-1:0] i_mask_b,
    input  logic [NCH-1:0] i_mask_c,
`endif
    output logic           o_irq,
    output logic           o_vec_valid,
    input  logic           i_vec_ready,
    output logic [1:0]     o_vec_bus,
    output logic [3:0]     o_vec_chan,
    output logic [NCH-1:0] o_pend_a,
    output logic [NCH-1:0] o_pend_b,
    output logic [NCH-1:0] o_pend_c,
    output logic           o_timeout
);

    localparam int NL = 3 * NCH;
    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t          r_state;
    logic [NL-1:0]   r_prev;
    logic [NL-1:0]   r_pend;
    logic            r_vec_valid;
    logic [1:0]      r_vec_bus;
    logic [3:0]      r_vec_chan;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;

    logic [NL-1:0]   w_req;
    logic [NL-1:0]   w_mask;
    logic [NL-1:0]   w_elig;
    logic [NL-1:0]   w_clr;
    logic            w_hs;
    logic            w_to_hit;
    logic            w_found;
    logic [1:0]      w_win_bus;
    logic [3:0]      w_win_chan;

    // Flat index ordering {C,B,A}: the lowest set index is the highest priority.
    assign w_req = {i_req_c, i_req_b, i_req_a};
`ifdef IRQ_MASK_EN
    assign w_mask = {i_mask_c, i_mask_b, i_mask_a};
`else
    assign w_mask = '1;
`endif
    assign w_elig   = r_pend & w_mask;
    assign w_hs     = r_vec_valid & i_vec_ready;
    assign w_to_hit = (ACK_TIMEOUT > 0) && (r_cnt == TO_LAST);

    always_comb begin
        w_found    = 1'b0;
        w_win_bus  = 2'd0;
        w_win_chan = 4'd0;
        for (int i = NL - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found    = 1'b1;
                w_win_bus  = 2'(i / NCH);
                w_win_chan = 4'(i % NCH);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NL; i++) begin
            w_clr[i] = w_hs && (i == int'(r_vec_bus) * NCH + int'(r_vec_chan));
        end
    end

    // A fresh edge on the bit being acknowledged keeps it pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= w_req;
            r_pend <= (r_pend & ~w_clr) | (w_req & ~r_prev);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_vec_valid <= 1'b0;
            r_vec_bus   <= 2'd0;
            r_vec_chan  <= 4'd0;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (o_irq) r_state <= RESOLVE;
                end
                RESOLVE: begin
                    if (w_found) begin
                        r_vec_bus   <= w_win_bus;
                        r_vec_chan  <= w_win_chan;
                        r_cnt       <= '0;
                        r_vec_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PRESENT: begin
                    if (i_vec_ready) begin
                        r_vec_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_to_hit) begin
                        r_vec_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_vec_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_irq       = |w_elig;
    assign o_vec_valid = r_vec_valid;
    assign o_vec_bus   = r_vec_bus;
    assign o_vec_chan  = r_vec_chan;
    assign o_pend_a    = r_pend[NCH-1:0];
    assign o_pend_b    = r_pend[2*NCH-1:NCH];
    assign o_pend_c    = r_pend[3*NCH-1:2*NCH];
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_irq_ack_sequencer;

    localparam int NCH = 9;
    localparam int TO  = 15;
    localparam int NL  = 3 * NCH;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] req_a, req_b, req_c;
    logic [NCH-1:0] mask_a, mask_b, mask_c;
    logic           irq, vec_valid, vec_ready, timeout;
    logic [1:0]     vec_bus;
    logic [3:0]     vec_chan;
    logic [NCH-1:0] pend_a, pend_b, pend_c;

    int n_vec = 0;
    int n_err = 0;

    irq_ack_sequencer #(.NCH(NCH), .ACK_TIMEOUT(TO)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_a    (req_a),
        .i_req_b    (req_b),
        .i_req_c    (req_c),
`ifdef IRQ_MASK_EN
        .i_mask_a   (mask_a),
        .i_mask_b   (mask_b),
        .i_mask_c   (mask_c),
`endif
        .o_irq      (irq),
        .o_vec_valid(vec_valid),
        .i_vec_ready(vec_ready),
        .o_vec_bus  (vec_bus),
        .o_vec_chan (vec_chan),
        .o_pend_a   (pend_a),
        .o_pend_b   (pend_b),
        .o_pend_c   (pend_c),
        .o_timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending set as a flat list in priority order, plus an offer
    // that starts two edges after interrupts are seen and lasts until accepted or aged out.
    bit [NL-1:0] m_pend, m_prev, m_mask;
    bit          m_offer, m_pick_next, m_to;
    int          m_bus, m_chan, m_age;

    always_comb begin
`ifdef IRQ_MASK_EN
        m_mask = {mask_c, mask_b, mask_a};
`else
        m_mask = '1;
`endif
    end

    always @(posedge clk) begin : model
        bit [NL-1:0] rq, elig, clr;
        rq  = {req_c, req_b, req_a};
        clr = '0;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_offer = 0; m_pick_next = 0; m_to = 0;
            m_bus = 0; m_chan = 0; m_age = 0;
        end else begin
            elig = m_pend & m_mask;
            m_to = 0;
            if (m_offer) begin
                if (vec_ready) begin
                    clr[m_bus * NCH + m_chan] = 1'b1;
                    m_offer = 0;
                end else if (TO > 0 && m_age + 1 == TO) begin
                    m_offer = 0;
                    m_to = 1;
                end else begin
                    m_age = m_age + 1;
                end
            end else if (m_pick_next) begin
                m_pick_next = 0;
                for (int i = 0; i < NL; i++) begin
                    if (elig[i] && !m_offer) begin
                        m_offer = 1; m_bus = i / NCH; m_chan = i % NCH; m_age = 0;
                    end
                end
            end else if (elig != 0) begin
                m_pick_next = 1;
            end
            m_pend = (m_pend & ~clr) | (rq & ~m_prev);
            m_prev = rq;
        end
    end

    task automatic test_reset;
        rst = 1; vec_ready = 0; req_a = '0; req_b = '0; req_c = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_vec++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", vec_valid); end
        n_vec++; if (vec_bus !== 2'd0 || vec_chan !== 4'd0) begin n_err++; $display("FAIL reset_vec: got %0d/%0d want 0/0", vec_bus, vec_chan); end
        n_vec++; if ({pend_c, pend_b, pend_a} !== '0) begin n_err++; $display("FAIL reset_pend: got %h want 0", {pend_c, pend_b, pend_a}); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_single;
        req_b[3] = 1'b1;
        @(negedge clk);
        n_vec++; if (pend_b !== NCH'(1 << 3)) begin n_err++; $display("FAIL single_pend: got %h want %h", pend_b, NCH'(1 << 3)); end
        n_vec++; if (irq !== 1'b1 || vec_valid !== 1'b0) begin n_err++; $display("FAIL single_irq: got irq=%b valid=%b want 1/0", irq, vec_valid); end
        @(negedge clk);
        n_vec++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got valid=%b want 0", vec_valid); end
        @(negedge clk);
        n_vec++; if (vec_valid !== 1'b1 || vec_bus !== 2'd1 || vec_chan !== 4'd3) begin n_err++; $display("FAIL single_vec: got v=%b %0d/%0d want 1 1/3", vec_valid, vec_bus, vec_chan); end
        vec_ready = 1;
        @(negedge clk);
        n_vec++; if (vec_valid !== 1'b0 || pend_b !== '0 || irq !== 1'b0) begin n_err++; $display("FAIL single_ack: got v=%b pend_b=%h irq=%b want 0 0 0", vec_valid, pend_b, irq); end
        vec_ready = 0; req_b = '0;
        @(negedge clk);
    endtask

    task automatic test_priority;
        int eb[3] = '{0, 0, 2};
        int ec[3] = '{2, 8, 0};
        bit want;
        req_c[0] = 1; req_a[8] = 1; req_a[2] = 1; vec_ready = 1;
        for (int t = 0; t <= 8; t++) begin
            @(negedge clk);
            want = (t == 2 || t == 5 || t == 8);
            n_vec++; if (vec_valid !== want) begin n_err++; $display("FAIL prio_valid_t%0d: got %b want %b", t, vec_valid, want); end
            if (want) begin
                n_vec++;
                if (vec_bus !== 2'(eb[(t - 2) / 3]) || vec_chan !== 4'(ec[(t - 2) / 3])) begin
                    n_err++; $display("FAIL prio_vec_t%0d: got %0d/%0d want %0d/%0d", t, vec_bus, vec_chan, eb[(t - 2) / 3], ec[(t - 2) / 3]);
                end
            end
        end
        @(negedge clk);
        n_vec++; if ({pend_c, pend_b, pend_a} !== '0 || irq !== 1'b0) begin n_err++; $display("FAIL prio_drain: got pend=%h irq=%b want 0 0", {pend_c, pend_b, pend_a}, irq); end
        vec_ready = 0; req_a = '0; req_c = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        bit wv, wt;
        req_c[7] = 1; vec_ready = 0;
        for (int t = 0; t <= TO + 4; t++) begin
            @(negedge clk);
            wv = (t >= 2 && t <= TO + 1) || t == TO + 4;
            wt = (t == TO + 2);
            n_vec++; if (vec_valid !== wv || timeout !== wt) begin n_err++; $display("FAIL to_t%0d: got v=%b to=%b want v=%b to=%b", t, vec_valid, timeout, wv, wt); end
            if (t == TO + 2) begin
                n_vec++; if (pend_c[7] !== 1'b1) begin n_err++; $display("FAIL to_pend_kept: got %b want 1", pend_c[7]); end
            end
        end
        n_vec++; if (vec_bus !== 2'd2 || vec_chan !== 4'd7) begin n_err++; $display("FAIL to_reoffer: got %0d/%0d want 2/7", vec_bus, vec_chan); end
        vec_ready = 1;
        @(negedge clk);
        n_vec++; if (pend_c !== '0 || vec_valid !== 1'b0) begin n_err++; $display("FAIL to_ack: got pend_c=%h v=%b want 0 0", pend_c, vec_valid); end
        vec_ready = 0; req_c = '0;
        @(negedge clk);
    endtask

    task automatic test_collision;
        req_a[5] = 1;
        @(negedge clk);
        req_a[5] = 0;
        repeat (2) @(negedge clk);
        n_vec++; if (vec_valid !== 1'b1 || vec_bus !== 2'd0 || vec_chan !== 4'd5) begin n_err++; $display("FAIL coll_first: got v=%b %0d/%0d want 1 0/5", vec_valid, vec_bus, vec_chan); end
        req_a[5] = 1; vec_ready = 1;
        @(negedge clk);
        n_vec++; if (pend_a[5] !== 1'b1 || vec_valid !== 1'b0) begin n_err++; $display("FAIL coll_setwins: got pend=%b v=%b want 1 0", pend_a[5], vec_valid); end
        repeat (2) @(negedge clk);
        n_vec++; if (vec_valid !== 1'b1 || vec_bus !== 2'd0 || vec_chan !== 4'd5) begin n_err++; $display("FAIL coll_again: got v=%b %0d/%0d want 1 0/5", vec_valid, vec_bus, vec_chan); end
        @(negedge clk);
        n_vec++; if (pend_a !== '0 || irq !== 1'b0) begin n_err++; $display("FAIL coll_clear: got pend_a=%h irq=%b want 0 0", pend_a, irq); end
        vec_ready = 0; req_a = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        req_b[6] = 1;
        repeat (3) @(negedge clk);
        n_vec++; if (vec_valid !== 1'b1) begin n_err++; $display("FAIL rmid_valid: got %b want 1", vec_valid); end
        rst = 1; vec_ready = 1;
        @(negedge clk);
        n_vec++;
        if (vec_valid !== 1'b0 || irq !== 1'b0 || pend_b !== '0 || vec_bus !== 2'd0 || vec_chan !== 4'd0 || timeout !== 1'b0) begin
            n_err++; $display("FAIL rmid_clear: got v=%b irq=%b pend_b=%h vec=%0d/%0d to=%b want all 0", vec_valid, irq, pend_b, vec_bus, vec_chan, timeout);
        end
        rst = 0;
        @(negedge clk);
        n_vec++; if (pend_b !== NCH'(1 << 6) || irq !== 1'b1) begin n_err++; $display("FAIL rmid_recapture: got pend_b=%h irq=%b want %h 1", pend_b, irq, NCH'(1 << 6)); end
        repeat (3) @(negedge clk);
        n_vec++; if (pend_b !== '0 || vec_valid !== 1'b0) begin n_err++; $display("FAIL rmid_drain: got pend_b=%h v=%b want 0 0", pend_b, vec_valid); end
        vec_ready = 0; req_b = '0;
        @(negedge clk);
    endtask

`ifdef IRQ_MASK_EN
    task automatic test_mask;
        bit seen;
        mask_a[1] = 0; req_a[1] = 1;
        @(negedge clk);
        n_vec++; if (pend_a[1] !== 1'b1 || irq !== 1'b0) begin n_err++; $display("FAIL mask_hold: got pend=%b irq=%b want 1 0", pend_a[1], irq); end
        repeat (3) @(negedge clk);
        n_vec++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL mask_novec: got %b want 0", vec_valid); end
        mask_a[1] = 1;
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            seen = vec_valid;
        end
        n_vec++; if (!seen || vec_bus !== 2'd0 || vec_chan !== 4'd1) begin n_err++; $display("FAIL mask_unmask: got seen=%b %0d/%0d want 1 0/1", seen, vec_bus, vec_chan); end
        vec_ready = 1;
        @(negedge clk);
        vec_ready = 0; req_a = '0;
        @(negedge clk);
    endtask
`endif

    task automatic test_random;
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_vec++; if (irq !== |(m_pend & m_mask)) begin n_err++; $display("FAIL rnd_irq c%0d: got %b want %b", c, irq, |(m_pend & m_mask)); end
            n_vec++; if (vec_valid !== m_offer) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, vec_valid, m_offer); end
            n_vec++; if (vec_bus !== 2'(m_bus) || vec_chan !== 4'(m_chan)) begin n_err++; $display("FAIL rnd_vec c%0d: got %0d/%0d want %0d/%0d", c, vec_bus, vec_chan, m_bus, m_chan); end
            n_vec++; if ({pend_c, pend_b, pend_a} !== m_pend) begin n_err++; $display("FAIL rnd_pend c%0d: got %h want %h", c, {pend_c, pend_b, pend_a}, m_pend); end
            n_vec++; if (timeout !== m_to) begin n_err++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, timeout, m_to); end
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 11) == 0) req_a[i] = ~req_a[i];
                if ($urandom_range(0, 11) == 0) req_b[i] = ~req_b[i];
                if ($urandom_range(0, 11) == 0) req_c[i] = ~req_c[i];
`ifdef IRQ_MASK_EN
                if ($urandom_range(0, 40) == 0) mask_a[i] = ~mask_a[i];
                if ($urandom_range(0, 40) == 0) mask_b[i] = ~mask_b[i];
                if ($urandom_range(0, 40) == 0) mask_c[i] = ~mask_c[i];
`endif
            end
            vec_ready = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 60 : 3));
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 0; vec_ready = 0;
    endtask

    initial begin
        rst = 1; vec_ready = 0;
        req_a = '0; req_b = '0; req_c = '0;
        mask_a = '1; mask_b = '1; mask_c = '1;
        test_reset;
        test_single;
        test_priority;
        test_timeout;
        test_collision;
        test_reset_mid;
`ifdef IRQ_MASK_EN
        test_mask;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
